tcp_slow_path_send_q: RTL and testbench

TCP_SLOW_PATH_SEND_Q -- requirements
Module: tcp_slow_path_send_q

---
 rtl/tcp_slow_path_send_q.sv | 137 +++++++++++++
 tb/tb_tcp_slow_path_send_q.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_slow_path_send_q.sv
// tcp_slow_path_send_q: first-word fall-through queue that carries slow-path
// TCP headers (e.g. SYN-ACKs) with their flow id and IP addresses from the
// connection-setup logic to the transmit path. Also reports live occupancy
// and the high-water mark of occupancy since reset.

package tcp_slow_path_send_q_pkg;

    localparam int FLOWID_W  = 16;
    localparam int IP_ADDR_W = 32;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [7:0]  flags;
        logic [15:0] window;
    } tcp_pkt_hdr;

    typedef struct packed {
        tcp_pkt_hdr           pkt;
        logic [FLOWID_W-1:0]  flowid;
        logic [IP_ADDR_W-1:0] src_ip;
        logic [IP_ADDR_W-1:0] dst_ip;
    } send_q_entry_t;

endpackage

module tcp_slow_path_send_q
    import tcp_slow_path_send_q_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  slow_path_send_pkt_enqueue_val,
    output logic                  slow_path_send_pkt_enqueue_rdy,
    input  tcp_pkt_hdr            slow_path_send_pkt_enqueue_pkt,
    input  logic [FLOWID_W-1:0]   slow_path_send_pkt_enqueue_flowid,
    input  logic [IP_ADDR_W-1:0]  slow_path_send_pkt_enqueue_src_ip,
    input  logic [IP_ADDR_W-1:0]  slow_path_send_pkt_enqueue_dst_ip,

    output logic                  slow_path_send_pkt_dequeue_val,
    input  logic                  slow_path_send_pkt_dequeue_rdy,
    output tcp_pkt_hdr            slow_path_send_pkt_dequeue_pkt,
    output logic [FLOWID_W-1:0]   slow_path_send_pkt_dequeue_flowid,
    output logic [IP_ADDR_W-1:0]  slow_path_send_pkt_dequeue_src_ip,
    output logic [IP_ADDR_W-1:0]  slow_path_send_pkt_dequeue_dst_ip,

    output logic [DEPTH_LOG2:0]   slow_path_send_q_count,
    output logic [DEPTH_LOG2:0]   slow_path_send_q_hwm
);

    localparam int                DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] ONE = DEPTH_LOG2'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [DEPTH_LOG2:0] r_count;
    logic [DEPTH_LOG2:0] r_hwm;
    send_q_entry_t       r_mem [DEPTH];

    logic                w_empty;
    logic                w_full;
    logic                w_enq;
    logic                w_deq;
    logic [DEPTH_LOG2:0] w_count_nxt;
    send_q_entry_t       w_head;
    send_q_entry_t       w_wr_entry;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);

    // Ready depends only on registered pointers: a dequeue in the same cycle
    // never opens a slot for a simultaneous enqueue when full.
    assign slow_path_send_pkt_enqueue_rdy = !w_full;
    assign slow_path_send_pkt_dequeue_val = !w_empty;

    // Handshakes are ignored on any edge sampled while reset is high.
    assign w_enq = slow_path_send_pkt_enqueue_val && !w_full  && !rst;
    assign w_deq = slow_path_send_pkt_dequeue_rdy && !w_empty && !rst;

    assign w_wr_entry = '{pkt:    slow_path_send_pkt_enqueue_pkt,
                          flowid: slow_path_send_pkt_enqueue_flowid,
                          src_ip: slow_path_send_pkt_enqueue_src_ip,
                          dst_ip: slow_path_send_pkt_enqueue_dst_ip};

    // Head entry is read straight from storage (first-word fall-through).
    assign w_head = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    assign slow_path_send_pkt_dequeue_pkt    = w_head.pkt;
    assign slow_path_send_pkt_dequeue_flowid = w_head.flowid;
    assign slow_path_send_pkt_dequeue_src_ip = w_head.src_ip;
    assign slow_path_send_pkt_dequeue_dst_ip = w_head.dst_ip;

    assign slow_path_send_q_count = r_count;
    assign slow_path_send_q_hwm   = r_hwm;

    // Next occupancy: +1 on enqueue only, -1 on dequeue only.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_count_nxt = r_count;
        unique case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + ONE;
            2'b01:   w_count_nxt = r_count - ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage write; entries written at edge N become visible at the head after edge N.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; empty/full come from the pointers, so stale entries are never observed.
        if (w_enq) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= w_wr_entry;
        end
    end

    // Pointer, occupancy and high-water-mark state.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hwm    <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + ONE;
            if (w_deq) r_rd_ptr <= r_rd_ptr + ONE;
            r_count <= w_count_nxt;
            // Occupancy never exceeds DEPTH, so the mark saturates there naturally.
            if (w_count_nxt > r_hwm) r_hwm <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_tcp_slow_path_send_q.sv
// Directed bench for tcp_slow_path_send_q: reset behaviour, single entry
// latency, fill/drain with full-plus-simultaneous handshakes, pointer wrap,
// backpressure stability and mid-operation reset.

module tb_tcp_slow_path_send_q;
    import tcp_slow_path_send_q_pkg::*;

    localparam int DEPTH_LOG2 = 2;
    localparam int CW = DEPTH_LOG2 + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 enq_val = 1'b0;
    logic                 enq_rdy;
    tcp_pkt_hdr           enq_pkt = '0;
    logic [FLOWID_W-1:0]  enq_flowid = '0;
    logic [IP_ADDR_W-1:0] enq_src_ip = '0;
    logic [IP_ADDR_W-1:0] enq_dst_ip = '0;
    logic                 deq_val;
    logic                 deq_rdy = 1'b0;
    tcp_pkt_hdr           deq_pkt;
    logic [FLOWID_W-1:0]  deq_flowid;
    logic [IP_ADDR_W-1:0] deq_src_ip;
    logic [IP_ADDR_W-1:0] deq_dst_ip;
    logic [CW-1:0]        q_count;
    logic [CW-1:0]        q_hwm;

    int n_vec = 0;
    int n_err = 0;

    tcp_slow_path_send_q #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk                               (clk),
        .rst                               (rst),
        .slow_path_send_pkt_enqueue_val    (enq_val),
        .slow_path_send_pkt_enqueue_rdy    (enq_rdy),
        .slow_path_send_pkt_enqueue_pkt    (enq_pkt),
        .slow_path_send_pkt_enqueue_flowid (enq_flowid),
        .slow_path_send_pkt_enqueue_src_ip (enq_src_ip),
        .slow_path_send_pkt_enqueue_dst_ip (enq_dst_ip),
        .slow_path_send_pkt_dequeue_val    (deq_val),
        .slow_path_send_pkt_dequeue_rdy    (deq_rdy),
        .slow_path_send_pkt_dequeue_pkt    (deq_pkt),
        .slow_path_send_pkt_dequeue_flowid (deq_flowid),
        .slow_path_send_pkt_dequeue_src_ip (deq_src_ip),
        .slow_path_send_pkt_dequeue_dst_ip (deq_dst_ip),
        .slow_path_send_q_count            (q_count),
        .slow_path_send_q_hwm              (q_hwm)
    );

    always #5 clk = ~clk;

    // Distinct, flowid-derived contents so every field is traceable to its entry.
    function automatic send_q_entry_t mk(input int fid);
        send_q_entry_t e;
        e.pkt.src_port = 16'h1000 + 16'(fid);
        e.pkt.dst_port = 16'h0050 ^ 16'(fid);
        e.pkt.seq_num  = 32'hA000_0000 | 32'(fid);
        e.pkt.ack_num  = 32'hB000_0000 + 32'(fid);
        e.pkt.flags    = 8'h12;
        e.pkt.window   = 16'hFF00 | 16'(fid);
        e.flowid       = FLOWID_W'(fid);
        e.src_ip       = 32'h0A00_0100 + 32'(fid);
        e.dst_ip       = 32'h0A00_0200 + 32'(fid);
        return e;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input send_q_entry_t e);
        enq_pkt    = e.pkt;
        enq_flowid = e.flowid;
        enq_src_ip = e.src_ip;
        enq_dst_ip = e.dst_ip;
    endtask

    function automatic send_q_entry_t head();
        return '{pkt: deq_pkt, flowid: deq_flowid, src_ip: deq_src_ip, dst_ip: deq_dst_ip};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        send_q_entry_t e;

        // ---- Reset state, handshakes ignored while rst is high ----
        #3;
        check("rst_enq_rdy", 256'(enq_rdy), 256'(1));
        check("rst_deq_val", 256'(deq_val), 256'(0));
        check("rst_count",   256'(q_count), 256'(0));
        check("rst_hwm",     256'(q_hwm),   256'(0));
        drive(mk(1));
        enq_val = 1'b1;
        tick();
        tick();
        check("rst_ignore_count", 256'(q_count), 256'(0));
        check("rst_ignore_val",   256'(deq_val), 256'(0));
        enq_val = 1'b0;
        rst = 1'b0;

        // ---- Single entry with spelled-out field values ----
        e = '0;
        e.flowid      = 16'd3;
        e.pkt.seq_num = 32'h0000_00FF;
        e.pkt.ack_num = 32'h0000_1001;
        e.pkt.flags   = 8'h12;
        e.src_ip      = 32'h0A00_0001;
        e.dst_ip      = 32'h0A00_0002;
        drive(e);
        enq_val = 1'b1;
        deq_rdy = 1'b1;
        #1;
        check("single_no_bypass", 256'(deq_val), 256'(0));
        tick();
        enq_val = 1'b0;
        check("single_val",    256'(deq_val),         256'(1));
        check("single_flowid", 256'(deq_flowid),      256'(16'd3));
        check("single_seq",    256'(deq_pkt.seq_num), 256'(32'hFF));
        check("single_ack",    256'(deq_pkt.ack_num), 256'(32'h1001));
        check("single_src",    256'(deq_src_ip),      256'(32'h0A00_0001));
        check("single_dst",    256'(deq_dst_ip),      256'(32'h0A00_0002));
        check("single_entry",  256'(head()),          256'(e));
        check("single_count1", 256'(q_count),         256'(1));
        tick();
        check("single_count0", 256'(q_count), 256'(0));
        check("single_hwm",    256'(q_hwm),   256'(1));
        check("single_empty",  256'(deq_val), 256'(0));

        // ---- Fill to full, flowid 4 refused ----
        deq_rdy = 1'b0;
        enq_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(mk(i));
            #1;
            check($sformatf("fill_rdy_%0d", i), 256'(enq_rdy), 256'(i < 4));
            tick();
        end
        check("fill_count", 256'(q_count), 256'(4));
        check("fill_hwm",   256'(q_hwm),   256'(4));
        check("fill_head",  256'(head()),  256'(mk(0)));

        // ---- Full + simultaneous: only the dequeue happens ----
        deq_rdy = 1'b1;
        check("full_sim_rdy", 256'(enq_rdy), 256'(0));
        tick();
        check("full_sim_count", 256'(q_count), 256'(3));
        check("full_sim_head",  256'(head()),  256'(mk(1)));
        check("full_sim_rdy2",  256'(enq_rdy), 256'(1));
        // Next cycle both handshakes fire; flowid 4 is accepted.
        tick();
        enq_val = 1'b0;
        check("both_count", 256'(q_count), 256'(3));
        for (int i = 2; i <= 4; i++) begin
            check($sformatf("drain_head_%0d", i), 256'(head()), 256'(mk(i)));
            tick();
        end
        check("drain_count", 256'(q_count), 256'(0));
        check("drain_val",   256'(deq_val), 256'(0));
        check("drain_hwm",   256'(q_hwm),   256'(4));

        // ---- Wrap: 20 entries streamed at full rate ----
        rst = 1'b1;
        #1;
        check("wrap_rst_hwm", 256'(q_hwm), 256'(0));
        rst = 1'b0;
        deq_rdy = 1'b1;
        enq_val = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(mk(20 + i));
            tick();
            check($sformatf("wrap_head_%0d", i),  256'(head()),  256'(mk(20 + i)));
            check($sformatf("wrap_count_%0d", i), 256'(q_count), 256'(1));
        end
        enq_val = 1'b0;
        tick();
        check("wrap_count_end", 256'(q_count), 256'(0));
        check("wrap_hwm",       256'(q_hwm),   256'(1));

        // ---- Backpressure: head flowid 7 held while flowid 8 enqueued ----
        deq_rdy = 1'b0;
        enq_val = 1'b1;
        drive(mk(7));
        tick();
        drive(mk(8));
        for (int i = 0; i < 5; i++) begin
            tick();
            enq_val = 1'b0;
            check($sformatf("hold_head_%0d", i), 256'(head()),  256'(mk(7)));
            check($sformatf("hold_val_%0d", i),  256'(deq_val), 256'(1));
        end
        check("hold_count", 256'(q_count), 256'(2));

        // ---- Reset mid-operation with count 3 ----
        enq_val = 1'b1;
        drive(mk(10));
        tick();
        enq_val = 1'b0;
        check("mid_pre_count", 256'(q_count), 256'(3));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_count", 256'(q_count), 256'(0));
        check("mid_rst_hwm",   256'(q_hwm),   256'(0));
        check("mid_rst_val",   256'(deq_val), 256'(0));
        check("mid_rst_rdy",   256'(enq_rdy), 256'(1));
        tick();
        rst = 1'b0;
        enq_val = 1'b1;
        drive(mk(9));
        tick();
        enq_val = 1'b0;
        check("post_rst_val",  256'(deq_val), 256'(1));
        check("post_rst_head", 256'(head()),  256'(mk(9)));
        deq_rdy = 1'b1;
        tick();
        check("post_rst_empty", 256'(deq_val), 256'(0));
        check("post_rst_hwm",   256'(q_hwm),   256'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
